// File: rtl/vga_pattern_engine.sv
// Parametrised VGA timing generator with a pixel-enable divider and a four-mode
// test-pattern source (solid, colour bars, checkerboard, bouncing square).
module vga_pattern_engine #(
  parameter int unsigned CD   = 12,
  parameter int unsigned HD   = 640,
  parameter int unsigned HF   = 16,
  parameter int unsigned HR   = 96,
  parameter int unsigned HB   = 48,
  parameter int unsigned VD   = 480,
  parameter int unsigned VF   = 10,
  parameter int unsigned VR   = 2,
  parameter int unsigned VB   = 33,
  parameter int unsigned DIV  = 4,
  parameter int unsigned SQ   = 32,
  parameter int unsigned STEP = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [CD-1:0] bg_rgb,
  input  logic [CD-1:0] fg_rgb,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb,
  output logic [10:0]   hc,
  output logic [10:0]   vc,
  output logic          video_on,
  output logic          frame_end
);

  localparam int unsigned HT    = HD + HF + HR + HB;
  localparam int unsigned VT    = VD + VF + VR + VB;
  localparam int unsigned CW    = CD / 3;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [10:0] HT_M1  = 11'(HT - 1);
  localparam logic [10:0] VT_M1  = 11'(VT - 1);
  localparam logic [10:0] H_VIS  = 11'(HD);
  localparam logic [10:0] V_VIS  = 11'(VD);
  localparam logic [10:0] HS_BEG = 11'(HD + HF);
  localparam logic [10:0] HS_END = 11'(HD + HF + HR - 1);
  localparam logic [10:0] VS_BEG = 11'(VD + VF);
  localparam logic [10:0] VS_END = 11'(VD + VF + VR - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [10:0]      sx_q, sx_d, sy_q, sy_d;
  logic             left_q, left_d, up_q, up_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic [CD-1:0]    rgb_q, rgb_d;
  logic [10:0]      hc_q, hc_d, vc_q, vc_d;
  logic             video_on_q, video_on_d;
  logic             frame_end_q, frame_end_d;

  logic             tick_c, last_h_c, last_v_c, frame_evt_c;
  logic             vis_c, hs_c, vs_c, in_sq_c;
  logic [2:0]       bar_c;
  logic [CD-1:0]    pix_c;

  // One bounce step along an axis of extent ext: returns {moving_back, new_pos}
  function automatic logic [11:0] bounce(input logic [10:0] pos, input logic back,
                                         input logic [10:0] ext);
    logic [11:0] r;
    r = {back, pos};
    if (!back) begin
      if (12'(pos) + 12'(SQ) + 12'(STEP) >= 12'(ext)) r = {1'b1, ext - 11'(SQ)};
      else                                             r = {1'b0, pos + 11'(STEP)};
    end else begin
      if (pos <= 11'(STEP)) r = {1'b0, 11'd0};
      else                  r = {1'b1, pos - 11'(STEP)};
    end
    return r;
  endfunction

  // Pixel divider, raster counters and frame-end housekeeping
  always_comb begin
    tick_c      = (cnt_q == CNT_W'(DIV - 1));
    last_h_c    = (hcnt_q == HT_M1);
    last_v_c    = (vcnt_q == VT_M1);
    frame_evt_c = tick_c && last_h_c && last_v_c;

    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick_c) begin
      if (last_h_c) begin
        hcnt_d = '0;
        vcnt_d = last_v_c ? 11'd0 : vcnt_q + 11'd1;
      end else begin
        hcnt_d = hcnt_q + 11'd1;
      end
    end

    mode_d = mode_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    left_d = left_q;
    up_d   = up_q;
    if (frame_evt_c) begin
      mode_d         = mode;
      {left_d, sx_d} = bounce(sx_q, left_q, H_VIS);
      {up_d, sy_d}   = bounce(sy_q, up_q, V_VIS);
    end
  end

  // Pattern decode for the pixel at (hcnt, vcnt)
  always_comb begin
    vis_c   = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    hs_c    = !((hcnt_q >= HS_BEG) && (hcnt_q <= HS_END));
    vs_c    = !((vcnt_q >= VS_BEG) && (vcnt_q <= VS_END));
    bar_c   = 3'((32'(hcnt_q) * 32'd8) / HD);
    in_sq_c = (hcnt_q >= sx_q) && (12'(hcnt_q) < 12'(sx_q) + 12'(SQ)) &&
              (vcnt_q >= sy_q) && (12'(vcnt_q) < 12'(sy_q) + 12'(SQ));

    pix_c = bg_rgb;
    unique case (mode_q)
      2'd0: pix_c = bg_rgb;
      2'd1: pix_c = {{CW{bar_c[2]}}, {CW{bar_c[1]}}, {CW{bar_c[0]}}};
      2'd2: pix_c = (hcnt_q[4] ^ vcnt_q[4]) ? fg_rgb : bg_rgb;
      2'd3: pix_c = in_sq_c ? fg_rgb : bg_rgb;
      default: pix_c = bg_rgb;
    endcase
  end

  // Output stage loads a whole pixel at once so sync, colour and coordinates align
  always_comb begin
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    rgb_d       = rgb_q;
    hc_d        = hc_q;
    vc_d        = vc_q;
    video_on_d  = video_on_q;
    frame_end_d = frame_evt_c;
    if (tick_c) begin
      hsync_d    = hs_c;
      vsync_d    = vs_c;
      rgb_d      = vis_c ? pix_c : '0;
      hc_d       = hcnt_q;
      vc_d       = vcnt_q;
      video_on_d = vis_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      mode_q      <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      left_q      <= 1'b0;
      up_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= '0;
      hc_q        <= '0;
      vc_q        <= '0;
      video_on_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      mode_q      <= mode_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      left_q      <= left_d;
      up_q        <= up_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      rgb_q       <= rgb_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      video_on_q  <= video_on_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign rgb       = rgb_q;
  assign hc        = hc_q;
  assign vc        = vc_q;
  assign video_on  = video_on_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Bench for vga_pattern_engine: two instances (DIV=1 and DIV=4) on a tiny raster,
// each checked every clock against a pixel-index reference model via scoreboard queues.
module tb_vga_pattern_engine;

  localparam int CD = 12, HD = 16, HF = 2, HR = 3, HB = 3;
  localparam int VD = 8, VF = 1, VR = 1, VB = 2, SQ = 4, STEP = 3;
  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;
  localparam int FP = HT * VT;
  localparam int CW = CD / 3;
  localparam int NF = 1024;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic [CD-1:0] rgb;
    logic [10:0]   hc;
    logic [10:0]   vc;
    logic          von;
    logic          fe;
  } pix_t;

  logic          clk, reset;
  logic [1:0]    mode;
  logic [CD-1:0] bg, fg;
  logic          hs0, vs0, von0, fe0, hs1, vs1, von1, fe1;
  logic [CD-1:0] rgb0, rgb1;
  logic [10:0]   hc0, vc0, hc1, vc1;
  pix_t          act0, act1;

  pix_t q0[$];
  pix_t q1[$];
  int   vectors, miscompares;
  bit   started;
  int   divs[2];
  int   clks[2];
  int   fmode[2][0:NF-1];
  pix_t last[2];

  vga_pattern_engine #(.CD(CD), .HD(HD), .HF(HF), .HR(HR), .HB(HB), .VD(VD), .VF(VF),
    .VR(VR), .VB(VB), .DIV(1), .SQ(SQ), .STEP(STEP)) u_div1 (
    .clk(clk), .reset(reset), .mode(mode), .bg_rgb(bg), .fg_rgb(fg),
    .hsync(hs0), .vsync(vs0), .rgb(rgb0), .hc(hc0), .vc(vc0),
    .video_on(von0), .frame_end(fe0));

  vga_pattern_engine #(.CD(CD), .HD(HD), .HF(HF), .HR(HR), .HB(HB), .VD(VD), .VF(VF),
    .VR(VR), .VB(VB), .DIV(4), .SQ(SQ), .STEP(STEP)) u_div4 (
    .clk(clk), .reset(reset), .mode(mode), .bg_rgb(bg), .fg_rgb(fg),
    .hsync(hs1), .vsync(vs1), .rgb(rgb1), .hc(hc1), .vc(vc1),
    .video_on(von1), .frame_end(fe1));

  assign act0 = {hs0, vs0, rgb0, hc0, vc0, von0, fe0};
  assign act1 = {hs1, vs1, rgb1, hc1, vc1, von1, fe1};

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic pix_t rst_pix();
    pix_t e;
    e     = '0;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    return e;
  endfunction

  // Square position after f frame-end events, straight from the bounce rules
  function automatic int sq_pos(int f, int ext);
    int pos, dir;
    pos = 0;
    dir = 1;
    for (int k = 0; k < f; k++) begin
      if (dir > 0) begin
        if (pos + SQ + STEP >= ext) begin pos = ext - SQ; dir = -1; end
        else pos = pos + STEP;
      end else begin
        if (pos <= STEP) begin pos = 0; dir = 1; end
        else pos = pos - STEP;
      end
    end
    return pos;
  endfunction

  function automatic pix_t model_pixel(int x, int y, int md, int f,
                                       logic [CD-1:0] b, logic [CD-1:0] g);
    pix_t e;
    int bar, sx, sy;
    logic [CD-1:0] fm;
    fm    = CD'((1 << CW) - 1);
    e     = '0;
    e.hs  = (x >= HD + HF && x < HD + HF + HR) ? 1'b0 : 1'b1;
    e.vs  = (y >= VD + VF && y < VD + VF + VR) ? 1'b0 : 1'b1;
    e.hc  = 11'(x);
    e.vc  = 11'(y);
    e.von = (x < HD && y < VD);
    if (e.von) begin
      case (md)
        0: e.rgb = b;
        1: begin
          bar = x * 8 / HD;
          if ((bar & 4) != 0) e.rgb = e.rgb | (fm << (2 * CW));
          if ((bar & 2) != 0) e.rgb = e.rgb | (fm << CW);
          if ((bar & 1) != 0) e.rgb = e.rgb | fm;
        end
        2: e.rgb = (((x / 16) % 2) != ((y / 16) % 2)) ? g : b;
        default: begin
          sx = sq_pos(f, HD);
          sy = sq_pos(f, VD);
          e.rgb = (x >= sx && x < sx + SQ && y >= sy && y < sy + SQ) ? g : b;
        end
      endcase
    end
    return e;
  endfunction

  // Expected outputs of instance i after the coming clock edge
  task automatic model_step(int i, logic r);
    pix_t e;
    int p, f, q, x, y;
    if (r) begin
      clks[i]     = 0;
      fmode[i][0] = 0;
      e           = rst_pix();
      last[i]     = e;
    end else begin
      clks[i]++;
      if (clks[i] % divs[i] == 0) begin
        p = clks[i] / divs[i] - 1;
        f = p / FP;
        q = p % FP;
        x = q % HT;
        y = q / HT;
        e = model_pixel(x, y, fmode[i][f % NF], f, bg, fg);
        if (x == HT - 1 && y == VT - 1) begin
          e.fe = 1'b1;
          fmode[i][(f + 1) % NF] = int'(mode);
        end
        last[i] = e;
      end else begin
        e    = last[i];
        e.fe = 1'b0;
      end
    end
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check(string nm, pix_t a, pix_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got hs=%b vs=%b rgb=%h hc=%0d vc=%0d on=%b fe=%b, want hs=%b vs=%b rgb=%h hc=%0d vc=%0d on=%b fe=%b",
               nm, $time, a.hs, a.vs, a.rgb, a.hc, a.vc, a.von, a.fe,
               e.hs, e.vs, e.rgb, e.hc, e.vc, e.von, e.fe);
    end
  endtask

  // Drive one clock's inputs on the falling edge and queue the expected response
  task automatic step(input logic r, input logic [1:0] m);
    logic was;
    @(negedge clk);
    was   = reset;
    reset = r;
    mode  = m;
    bg    = CD'($urandom);
    fg    = CD'($urandom);
    model_step(0, r);
    model_step(1, r);
    started = 1'b1;
    if (r && !was) begin
      #1;
      check("div1_async_reset", act0, rst_pix());
      check("div4_async_reset", act1, rst_pix());
    end
  endtask

  // Monitor: every clock both instances present an output to compare
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (q0.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL div1_queue: no expected entry");
        end else check("div1", act0, q0.pop_front());
        if (q1.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL div4_queue: no expected entry");
        end else check("div4", act1, q1.pop_front());
      end
    end
  end

  initial begin
    logic [1:0] md;
    reset       = 1'b1;
    mode        = 2'd0;
    bg          = '0;
    fg          = '0;
    started     = 1'b0;
    vectors     = 0;
    miscompares = 0;
    divs[0]     = 1;
    divs[1]     = 4;
    clks[0]     = 0;
    clks[1]     = 0;
    fmode[0][0] = 0;
    fmode[1][0] = 0;
    last[0]     = rst_pix();
    last[1]     = rst_pix();

    repeat (3) step(1'b1, 2'd0);
    // Square mode until the DIV=1 raster shows (5,3) in frame 3 (square at x=9)
    while (clks[0] < 3 * FP + 3 * HT + 6) step(1'b0, 2'd3);
    step(1'b1, 2'd3);
    step(1'b1, 2'd3);
    repeat (700)   step(1'b0, 2'd0);
    repeat (700)   step(1'b0, 2'd2);
    repeat (700)   step(1'b0, 2'd1);
    repeat (12000) step(1'b0, 2'd3);
    md = 2'd3;
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) md = 2'($urandom);
      step(1'b0, md);
    end

    @(posedge clk);
    #3;
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expected entries left, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pattern_engine.md
# vga_pattern_engine

Parametrised successor to the VGA demo top: a single block with configurable VGA timing and an on-chip pixel-enable divider. It drives a four-mode test-pattern generator: solid, colour bars, checkerboard, and a bouncing square that moves once per frame. Sync, RGB and coordinate outputs are registered together so they stay aligned, and the block drives the VGA pins directly.

## Interface
- CD, 12, colour depth; must be a multiple of 3, split R|G|B MSB-first
- HD, 640, horizontal display pixels; multiple of 8
- HF, 16, horizontal front porch
- HR, 96, horizontal sync pulse width
- HB, 48, horizontal back porch
- VD, 480, vertical display lines
- VF, 10, vertical front porch
- VR, 2, vertical sync pulse width
- VB, 33, vertical back porch
- DIV, 4, clk cycles per pixel (≥1)
- SQ, 32, square side in pixels (<HD, <VD)
- STEP, 2, square motion per frame in pixels (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 square
- bg_rgb  in  CD  background colour
- fg_rgb  in  CD  foreground colour (checker, square)
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- rgb  out  CD  pixel colour; 0 during blanking
- hc  out  11  x coordinate of pixel currently on rgb
- vc  out  11  y coordinate of pixel currently on rgb
- video_on  out  1  rgb is in the visible area
- frame_end  out  1  one-clk pulse, last pixel of frame issued

## Operation
- Derived totals: HT = HD+HF+HR+HB and VT = VD+VF+VR+VB.
- The tick counter runs 0..DIV-1. tick = (cnt == DIV-1); with DIV=1, tick is always 1.
- Internal counters hcnt and vcnt advance only on tick.
  - hcnt wraps HT-1→0.
  - vcnt increments when hcnt wraps, and wraps VT-1→0.
- Sync decode: hsync is low when HD+HF ≤ hcnt ≤ HD+HF+HR-1. vsync is low when VD+VF ≤ vcnt ≤ VD+VF+VR-1.
- Visible area: hcnt<HD and vcnt<VD. Outside it, rgb is 0.
- Patterns in the visible area use mode_q, the latched copy of mode:
  - 0: rgb = bg_rgb.
  - 1: bar index b = floor(hcnt·8/HD), range 0..7. R field is all-ones if b[2], G if b[1], B if b[0]; otherwise 0.
  - 2: rgb = fg_rgb if hcnt[4]^vcnt[4], else bg_rgb.
  - 3: rgb = fg_rgb if sx≤hcnt<sx+SQ and sy≤vcnt<sy+SQ, else bg_rgb.
- Frame-end event fires on a tick with hcnt=HT-1 and vcnt=VT-1. It does three things:
  - latches mode into mode_q;
  - updates the square;
  - pulses frame_end for one clk, aligned with the registered outputs of that pixel.
- Square update, x axis (y identical with VD/sy/dy):
  - Moving right: if sx+SQ+STEP ≥ HD, then sx=HD-SQ and the direction flips to left; else sx += STEP.
  - Moving left: if sx ≤ STEP, then sx=0 and the direction flips to right; else sx -= STEP.
  - Both axes update in the same event, so corner hits flip both directions.
- Changing mode mid-frame has no effect until the next frame begins.

## Timing
- Registered outputs hsync, vsync, rgb, hc, vc and video_on load together on tick, one clk after their decode. Each set of outputs describes a single pixel.
- Latency from counter to pins is one tick.
- Reset values (asynchronous, applied immediately):
  - cnt=0, hcnt=vcnt=0, mode_q=0
  - sx=sy=0, directions right/down
  - hsync=vsync=1, rgb=0, hc=vc=0, video_on=0, frame_end=0
- After reset deassertion, the first tick issues pixel (0,0).
- Reset asserted mid-frame forces all state to the reset values within the same cycle. The next frame then restarts at (0,0) with square mode_q=0.
- bg_rgb and fg_rgb are sampled every tick, with no latching.

## Test plan
- Reset and line timing:
  - Stimulus: DIV=1, HD=16, HF=2, HR=3, HB=3, VD=8, VF=1, VR=1, VB=2.
  - Required: hsync is low for exactly 3 clks per 24-clk line, starting at hc=18. vsync is low for exactly 1 line (24 clks) per 12-line frame. frame_end pulses every 288 clks.
- Pixel divider:
  - Stimulus: DIV=4.
  - Required: hc advances every 4 clks, and all outputs hold stable between ticks.
- Colour bars:
  - Stimulus: mode=1, HD=16, CD=12.
  - Required: hc=0–1 gives rgb=0x000, hc=2–3 gives 0x00F, hc=14–15 gives 0xFFF, and rgb=0 at hc≥16.
- Mode latch:
  - Stimulus: switch mode 0→2 at mid-frame.
  - Required: the remainder of that frame stays bg_rgb. The checker pattern appears from pixel (0,0) of the next frame.
- Bounce:
  - Stimulus: mode=3, HD=16, VD=8, SQ=4, STEP=3.
  - Required: sx follows 0,3,6,9,12 (flip),9,6,3,0 (flip). sy follows 0,3,4 (flip),1,0 (flip).
- Reset mid-frame:
  - Stimulus: assert reset for 2 clks at hc=5, vc=3 while the square is at sx=9.
  - Required: outputs immediately show hsync=vsync=1 and rgb=0. After release, the square is at (0,0) and mode_q=0.
